// File: rtl/poly_bram_loader_if.sv
// poly_bram_loader_if: command/status, BRAM port and register-bank signals of the loader (master = loader side, slave = environment side)
interface poly_bram_loader_if #(
  parameter int WORD_WIDTH = 17,
  parameter int ADDR_WIDTH = 10
);
  logic                  start_load_i;
  logic                  start_store_i;
  logic                  busy_o;
  logic                  load_done_o;
  logic                  store_done_o;
  logic                  bram_en_o;
  logic                  bram_we_o;
  logic [ADDR_WIDTH-1:0] bram_addr_o;
  logic [WORD_WIDTH-1:0] bram_din_o;
  logic [WORD_WIDTH-1:0] bram_dout_i;
  logic [1:0]            INPUT_reg_sel_o;
  logic                  INPUT_reg_en_o;
  logic [WORD_WIDTH-1:0] INPUT_reg_din_o;
  logic                  RES_reg_shift_o;
  logic [WORD_WIDTH-1:0] RES_reg_dout_i;
  modport master (
    input  start_load_i, start_store_i, bram_dout_i, RES_reg_dout_i,
    output busy_o, load_done_o, store_done_o, bram_en_o, bram_we_o, bram_addr_o, bram_din_o,
           INPUT_reg_sel_o, INPUT_reg_en_o, INPUT_reg_din_o, RES_reg_shift_o
  );
  modport slave (
    output start_load_i, start_store_i, bram_dout_i, RES_reg_dout_i,
    input  busy_o, load_done_o, store_done_o, bram_en_o, bram_we_o, bram_addr_o, bram_din_o,
           INPUT_reg_sel_o, INPUT_reg_en_o, INPUT_reg_din_o, RES_reg_shift_o
  );
endinterface

// File: rtl/poly_bram_loader.sv
// poly_bram_loader: streams A/B/M/M_prime_0 from BRAM into the register bank and writes the result register back (ports: clock_i, reset_i, bus = commands, BRAM port, bank port)
module poly_bram_loader #(
  parameter int WORD_WIDTH = 17,
  parameter int N          = 5,
  parameter int S          = 4,
  parameter int ADDR_WIDTH = 10
) (
  input logic                 clock_i,
  input logic                 reset_i,
  poly_bram_loader_if.master  bus
);
  localparam int NS = N * S;
  localparam logic [ADDR_WIDTH-1:0] A_END      = ADDR_WIDTH'(NS);
  localparam logic [ADDR_WIDTH-1:0] B_END      = ADDR_WIDTH'(2 * NS);
  localparam logic [ADDR_WIDTH-1:0] M_END      = ADDR_WIDTH'(3 * NS);
  localparam logic [ADDR_WIDTH-1:0] LOAD_LAST  = ADDR_WIDTH'(3 * NS + N - 1);
  localparam logic [ADDR_WIDTH-1:0] RES_BASE   = ADDR_WIDTH'(3 * NS + N);
  localparam logic [ADDR_WIDTH-1:0] STORE_LAST = ADDR_WIDTH'(NS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);
  typedef enum logic [2:0] {IDLE, LOAD, LOAD_DRAIN, STORE, DONE} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, addr_q, addr_d;
  logic [1:0]            sel_q, sel_d;
  logic                  busy_q, busy_d, ld_done_q, ld_done_d, st_done_q, st_done_d;
  logic                  en_q, en_d, we_q, we_d, reg_en_q, reg_en_d, shift_q, shift_d;
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      reg_en_q  <= 1'b0;
      shift_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      ld_done_q <= ld_done_d;
      st_done_q <= st_done_d;
      en_q      <= en_d;
      we_q      <= we_d;
      reg_en_q  <= reg_en_d;
      shift_q   <= shift_d;
    end
  end
  // Outputs are registered: the values computed here appear in the cycle after the current one,
  // so a bank strobe decided while address k is on the bus lands exactly one cycle behind it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    ld_done_d = 1'b0;
    st_done_d = 1'b0;
    en_d      = 1'b0;
    we_d      = 1'b0;
    reg_en_d  = 1'b0;
    shift_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_load_i) begin
          state_d = LOAD;
          cnt_d   = '0;
          addr_d  = '0;
          en_d    = 1'b1;
        end else if (bus.start_store_i) begin
          state_d = STORE;
          cnt_d   = '0;
          addr_d  = RES_BASE;
          en_d    = 1'b1;
          we_d    = 1'b1;
          shift_d = 1'b1;
        end
      end
      LOAD: begin
        reg_en_d = 1'b1;
        sel_d    = cnt_q < A_END ? 2'd0 : cnt_q < B_END ? 2'd1 : cnt_q < M_END ? 2'd2 : 2'd3;
        if (cnt_q == LOAD_LAST) begin
          state_d = LOAD_DRAIN;
        end else begin
          cnt_d  = cnt_q + ONE;
          addr_d = cnt_q + ONE;
          en_d   = 1'b1;
        end
      end
      LOAD_DRAIN: begin
        state_d   = DONE;
        ld_done_d = 1'b1;
      end
      STORE: begin
        if (cnt_q == STORE_LAST) begin
          state_d   = DONE;
          st_done_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + ONE;
          addr_d  = addr_q + ONE;
          en_d    = 1'b1;
          we_d    = 1'b1;
          shift_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        addr_d  = '0;
        sel_d   = '0;
      end
    endcase
    busy_d = state_d != IDLE;
  end
  assign bus.busy_o          = busy_q;
  assign bus.load_done_o     = ld_done_q;
  assign bus.store_done_o    = st_done_q;
  assign bus.bram_en_o       = en_q;
  assign bus.bram_we_o       = we_q;
  assign bus.bram_addr_o     = addr_q;
  // Write data must be the result word present on the same edge as the shift, so it bypasses the registers.
  assign bus.bram_din_o      = we_q ? bus.RES_reg_dout_i : {WORD_WIDTH{1'b0}};
  assign bus.INPUT_reg_sel_o = sel_q;
  assign bus.INPUT_reg_en_o  = reg_en_q;
  assign bus.INPUT_reg_din_o = bus.bram_dout_i;
  assign bus.RES_reg_shift_o = shift_q;
endmodule

// File: tb/tb_poly_bram_loader.sv
// tb_poly_bram_loader: randomized and directed checks of poly_bram_loader against a cycle-index reference model
module tb_poly_bram_loader;
  localparam int W = 17, N = 5, S = 4, AW = 10, NS = N * S, LW = 3 * NS + N, RB = 3 * NS + N;
  localparam int LOAD_BUSY = LW + 2, STORE_BUSY = NS + 1;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  poly_bram_loader_if #(.WORD_WIDTH(W), .ADDR_WIDTH(AW)) bus();
  poly_bram_loader #(.WORD_WIDTH(W), .N(N), .S(S), .ADDR_WIDTH(AW)) dut (
    .clock_i(clk),
    .reset_i(rst),
    .bus(bus)
  );
  logic [W-1:0] mem [LW];
  logic [W-1:0] wmem [1 << AW];
  logic [W-1:0] res [NS];
  logic [W-1:0] rdata = '0;
  logic [W+1:0] capq [$];
  int ptr = 0, we_total = 0, errors = 0, checks = 0, mode = 0, t = 0;
  bit chk_on = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  assign bus.bram_dout_i    = rdata;
  assign bus.RES_reg_dout_i = ptr < NS ? res[ptr] : '0;
  // Environment: synchronous BRAM, result register consumed by shifts, bank capture log.
  always @(posedge clk) begin
    if (bus.bram_en_o && !bus.bram_we_o) rdata <= int'(bus.bram_addr_o) < LW ? mem[bus.bram_addr_o] : '0;
    if (bus.bram_en_o && bus.bram_we_o) begin
      wmem[bus.bram_addr_o] <= bus.bram_din_o;
      we_total <= we_total + 1;
    end
    if (bus.INPUT_reg_en_o) capq.push_back({bus.INPUT_reg_sel_o, bus.INPUT_reg_din_o});
    ptr <= !bus.busy_o ? 0 : bus.RES_reg_shift_o ? ptr + 1 : ptr;
  end
  // Reference model: which operation is running and how many cycles into it we are.
  always @(posedge clk) begin
    if (rst) begin
      mode <= 0;
      t <= 0;
    end else if (mode == 0) begin
      if (bus.start_load_i) begin
        mode <= 1;
        t <= 1;
      end else if (bus.start_store_i) begin
        mode <= 2;
        t <= 1;
      end
    end else if ((mode == 1 && t == LOAD_BUSY) || (mode == 2 && t == STORE_BUSY)) begin
      mode <= 0;
      t <= 0;
    end else t <= t + 1;
  end
  always @(negedge clk) begin
    logic e_en, e_we, e_reg, e_ld, e_sd;
    int k;
    if (chk_on) begin
      e_ld  = mode == 1 && t == LOAD_BUSY;
      e_sd  = mode == 2 && t == STORE_BUSY;
      e_we  = mode == 2 && t <= NS;
      e_en  = (mode == 1 && t <= LW) || e_we;
      e_reg = mode == 1 && t >= 2 && t <= LW + 1;
      k     = t - 2;
      chk("ctrl{busy,ld,sd,en,we,reg_en,shift}",
          32'({bus.busy_o, bus.load_done_o, bus.store_done_o, bus.bram_en_o, bus.bram_we_o, bus.INPUT_reg_en_o, bus.RES_reg_shift_o}),
          32'({mode != 0, e_ld, e_sd, e_en, e_we, e_reg, e_we}));
      if (e_en) chk("bram_addr", 32'(bus.bram_addr_o), 32'(mode == 1 ? t - 1 : RB + t - 1));
      if (e_we) chk("bram_din", 32'(bus.bram_din_o), 32'(res[t-1]));
      if (e_reg) begin
        chk("reg_sel", 32'(bus.INPUT_reg_sel_o), 32'(k < 3 * NS ? k / NS : 3));
        chk("reg_din", 32'(bus.INPUT_reg_din_o), 32'(mem[k]));
      end
      if (bus.INPUT_reg_en_o && bus.RES_reg_shift_o) chk("en_shift_overlap", 32'd1, 32'd0);
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse(input bit ld, input bit st);
    bus.start_load_i  = ld;
    bus.start_store_i = st;
    cyc();
    bus.start_load_i  = 1'b0;
    bus.start_store_i = 1'b0;
  endtask
  task automatic wait_idle(input string nm);
    int n = 0;
    while (bus.busy_o && n < 200) begin
      cyc();
      n++;
    end
    chk(nm, 32'(bus.busy_o), 32'd0);
  endtask
  initial begin
    int base, wbase, n;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
  initial begin
    int base, wbase, n;
    bus.start_load_i  = 1'b0;
    bus.start_store_i = 1'b0;
    for (int i = 0; i < LW; i++) mem[i] = W'(i);
    for (int i = 0; i < NS; i++) res[i] = W'(32'h100 + i);
    repeat (3) cyc();
    rst = 1'b0;
    chk_on = 1'b1;
    repeat (10) cyc();
    chk("idle_ctrl", 32'({bus.busy_o, bus.load_done_o, bus.store_done_o, bus.bram_en_o, bus.bram_we_o, bus.INPUT_reg_en_o, bus.RES_reg_shift_o}), 32'd0);
    chk("idle_addr", 32'(bus.bram_addr_o), 32'd0);
    chk("idle_bdin", 32'(bus.bram_din_o), 32'd0);
    chk("idle_sel", 32'(bus.INPUT_reg_sel_o), 32'd0);
    // Directed load with word[a] = a.
    base = capq.size();
    pulse(1, 0);
    wait_idle("load_idle");
    chk("load_count", 32'(capq.size() - base), 32'd65);
    for (int k = 0; k < 65 && base + k < capq.size(); k++)
      chk("load_word", 32'(capq[base+k]), 32'({2'(k < 20 ? 0 : k < 40 ? 1 : k < 60 ? 2 : 3), W'(k)}));
    chk("bank_a0", 32'(capq[base]), 32'd0);
    // Directed store of 0x100..0x113.
    wbase = we_total;
    pulse(0, 1);
    wait_idle("store_idle");
    chk("store_count", 32'(we_total - wbase), 32'd20);
    for (int i = 0; i < NS; i++) chk("store_word", 32'(wmem[RB+i]), 32'h100 + i);
    // Both starts together, then a store pulse mid-load.
    wbase = we_total;
    base = capq.size();
    pulse(1, 1);
    repeat (10) cyc();
    pulse(0, 1);
    wait_idle("both_idle");
    chk("both_no_write", 32'(we_total - wbase), 32'd0);
    chk("both_load_count", 32'(capq.size() - base), 32'd65);
    // Reset during load cycle 30.
    pulse(1, 0);
    repeat (29) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_ctrl", 32'({bus.busy_o, bus.load_done_o, bus.store_done_o, bus.bram_en_o, bus.bram_we_o, bus.INPUT_reg_en_o, bus.RES_reg_shift_o}), 32'd0);
    base = capq.size();
    pulse(1, 0);
    wait_idle("reload_idle");
    chk("reload_count", 32'(capq.size() - base), 32'd65);
    // Store accepted in the first IDLE cycle after load_done.
    pulse(1, 0);
    n = 0;
    while (!bus.load_done_o && n < 100) begin
      cyc();
      n++;
    end
    chk("b2b_load_done", 32'(bus.load_done_o), 32'd1);
    cyc();
    wbase = we_total;
    pulse(0, 1);
    wait_idle("b2b_idle");
    chk("b2b_store_count", 32'(we_total - wbase), 32'd20);
    // Randomized operations with stray starts and occasional aborts.
    for (int it = 0; it < 40; it++) begin
      int op, kind;
      repeat ($urandom_range(0, 3)) cyc();
      for (int i = 0; i < LW; i++) mem[i] = W'($urandom);
      for (int i = 0; i < NS; i++) res[i] = W'($urandom);
      op = $urandom_range(0, 2);
      pulse(op != 1, op != 0);
      kind = $urandom_range(0, 7);
      repeat ($urandom_range(1, 12)) cyc();
      if (kind == 0) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end else if (kind < 3) pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_idle("rand_idle");
    end
    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
